// File: rtl/password_lock_ctrl.sv
// -----------------------------------------------------------------------------
// password_lock_ctrl
//   Sequencer for a 4-digit password lock.
//   - Collects BCD digits, one per enter pulse.
//   - Compares the four digits with PASSWORD.
//   - Counts consecutive failed attempts. Reaching MAX_FAIL starts a timed lockout.
//   - Drives four display codes, one per seven-segment decoder.
//   Display code map: 0-9 digit, 10 'P', 11 'A', 15 fill glyph.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   digit_in  in   4  BCD digit; values above 9 are ignored
//   enter     in   1  one-cycle pulse, stores digit_in while collecting
//   clear     in   1  one-cycle pulse, discards the entry / leaves OPEN or ERROR
//   disp3     out  7  display code, leftmost position (first digit entered)
//   disp2     out  7  display code
//   disp1     out  7  display code
//   disp0     out  7  display code, rightmost position
//   unlocked  out  1  high while OPEN
//   alarm     out  1  high while LOCKOUT
// -----------------------------------------------------------------------------
module password_lock_ctrl #(
    parameter logic [15:0] PASSWORD    = 16'h1234,
    parameter int          MAX_FAIL    = 3,
    parameter int          OPEN_CYCLES = 50000000,
    parameter int          ERR_CYCLES  = 25000000,
    parameter int          LOCK_CYCLES = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       enter,
    input  logic       clear,
    output logic [6:0] disp3,
    output logic [6:0] disp2,
    output logic [6:0] disp1,
    output logic [6:0] disp0,
    output logic       unlocked,
    output logic       alarm
);

    localparam int MAX_OE  = (OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES;
    localparam int MAX_CYC = (MAX_OE > LOCK_CYCLES) ? MAX_OE : LOCK_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] ERR_LAST   = TW'(ERR_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_CYCLES - 1);
    localparam logic [2:0]    MAX_FAIL_C = 3'(MAX_FAIL);
    localparam logic [3:0]    FILL       = 4'd15;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_ERROR,
        ST_LOCKOUT
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      idx_reg, idx_next;
    logic [3:0]      digit_buf_reg [4];
    logic [3:0]      digit_buf_next [4];
    logic [2:0]      fail_cnt_reg, fail_cnt_next;
    logic [TW-1:0]   timer_reg, timer_next;

    logic            code_match;
    logic [3:0]      entry_code [4];
    logic [3:0]      check_code [4];
    logic [3:0]      code [4];

    // digit_buf_reg[0] holds the first digit, which is compared against PASSWORD[15:12].
    assign code_match = ({digit_buf_reg[0], digit_buf_reg[1],
                          digit_buf_reg[2], digit_buf_reg[3]} == PASSWORD);

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_ENTRY;
            idx_reg      <= 2'd0;
            fail_cnt_reg <= 3'd0;
            timer_reg    <= '0;
            for (int i = 0; i < 4; i++) begin
                digit_buf_reg[i] <= 4'd0;
            end
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            fail_cnt_reg  <= fail_cnt_next;
            timer_reg     <= timer_next;
            digit_buf_reg <= digit_buf_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        fail_cnt_next  = fail_cnt_reg;
        digit_buf_next = digit_buf_reg;

        case (state_reg)
            ST_ENTRY: begin
                if (clear) begin
                    idx_next = 2'd0;
                end else if (enter && (digit_in <= 4'd9)) begin
                    digit_buf_next[idx_reg] = digit_in;
                    if (idx_reg == 2'd3) begin
                        // The 4th digit restarts the index, so the next ENTRY begins empty.
                        idx_next   = 2'd0;
                        state_next = ST_CHECK;
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (code_match) begin
                    fail_cnt_next = 3'd0;
                    state_next    = ST_OPEN;
                end else begin
                    fail_cnt_next = fail_cnt_reg + 3'd1;
                    if ((fail_cnt_reg + 3'd1) == MAX_FAIL_C) begin
                        state_next = ST_LOCKOUT;
                    end else begin
                        state_next = ST_ERROR;
                    end
                end
            end
            ST_OPEN: begin
                if (clear || (timer_reg == OPEN_LAST)) begin
                    idx_next   = 2'd0;
                    state_next = ST_ENTRY;
                end
            end
            ST_ERROR: begin
                if (clear || (timer_reg == ERR_LAST)) begin
                    idx_next   = 2'd0;
                    state_next = ST_ENTRY;
                end
            end
            ST_LOCKOUT: begin
                if (timer_reg == LOCK_LAST) begin
                    idx_next      = 2'd0;
                    fail_cnt_next = 3'd0;
                    state_next    = ST_ENTRY;
                end
            end
            default: begin
                idx_next   = 2'd0;
                state_next = ST_ENTRY;
            end
        endcase

        // The timer restarts on every state change. It is held at zero in ENTRY,
        // which has no time limit, so the counter cannot wrap there.
        if ((state_next != state_reg) || (state_reg == ST_ENTRY)) begin
            timer_next = '0;
        end else begin
            timer_next = timer_reg + TW'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Display decode (Moore, from registered state only)
    // ---------------------------------------------------------------------
    // Position gi maps to buffer slot 3-gi. It shows a digit once that slot has been filled.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pos
            assign entry_code[gi] = (2'(3 - gi) < idx_reg) ? digit_buf_reg[3-gi] : FILL;
            assign check_code[gi] = digit_buf_reg[3-gi];
        end
    endgenerate

    always_comb begin
        unlocked = 1'b0;
        alarm    = 1'b0;
        code     = '{FILL, FILL, FILL, FILL};

        case (state_reg)
            ST_ENTRY: begin
                code = entry_code;
            end
            ST_CHECK: begin
                code = check_code;
            end
            ST_OPEN: begin
                code[3]  = 4'd10;
                code[2]  = 4'd11;
                code[1]  = 4'd5;
                code[0]  = 4'd5;
                unlocked = 1'b1;
            end
            ST_ERROR: begin
                // Shows the number of attempts remaining before lockout.
                code[0] = {1'b0, MAX_FAIL_C - fail_cnt_reg};
            end
            ST_LOCKOUT: begin
                alarm = 1'b1;
            end
            default: begin
                code = '{FILL, FILL, FILL, FILL};
            end
        endcase
    end

    assign disp3 = {3'b000, code[3]};
    assign disp2 = {3'b000, code[2]};
    assign disp1 = {3'b000, code[1]};
    assign disp0 = {3'b000, code[0]};

endmodule

// File: tb/tb_password_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_password_lock_ctrl
//   Directed, self-checking bench for password_lock_ctrl.
//   Parameters: PASSWORD 1234, MAX_FAIL 3, OPEN 8, ERR 4, LOCK 16.
//   Each stimulus cycle pushes the expected outputs onto a scoreboard queue.
//   The entry is popped and compared one time unit after the clock edge.
// -----------------------------------------------------------------------------
module tb_password_lock_ctrl;

    localparam logic [3:0] F = 4'd15;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_in;
    logic       enter;
    logic       clear;
    logic [6:0] disp3, disp2, disp1, disp0;
    logic       unlocked, alarm;

    always #5 clk = ~clk;

    password_lock_ctrl #(
        .PASSWORD   (16'h1234),
        .MAX_FAIL   (3),
        .OPEN_CYCLES(8),
        .ERR_CYCLES (4),
        .LOCK_CYCLES(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .digit_in(digit_in),
        .enter   (enter),
        .clear   (clear),
        .disp3   (disp3),
        .disp2   (disp2),
        .disp1   (disp1),
        .disp0   (disp0),
        .unlocked(unlocked),
        .alarm   (alarm)
    );

    typedef struct {
        string       tag;
        logic [29:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [3:0] c3, input logic [3:0] c2,
                        input logic [3:0] c1, input logic [3:0] c0,
                        input logic u, input logic a);
        exp_t e;
        e.tag = tag;
        e.val = {3'b000, c3, 3'b000, c2, 3'b000, c1, 3'b000, c0, u, a};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [29:0] obs;
        obs = {disp3, disp2, disp1, disp0, unlocked, alarm};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
        $display("check %0d %s disp=%0d,%0d,%0d,%0d unlocked=%0b alarm=%0b",
                 checks, (sb.size() == 0) ? "done" : "pending",
                 disp3, disp2, disp1, disp0, unlocked, alarm);
    endtask

    // One clock of stimulus. Pulses are dropped right after the edge.
    task automatic cyc(input logic e, input logic c, input logic [3:0] d, input string tag,
                       input logic [3:0] c3, input logic [3:0] c2,
                       input logic [3:0] c1, input logic [3:0] c0,
                       input logic u, input logic a);
        enter    = e;
        clear    = c;
        digit_in = d;
        push(tag, c3, c2, c1, c0, u, a);
        @(posedge clk);
        #1;
        enter = 1'b0;
        clear = 1'b0;
        check_out();
    endtask

    task automatic idle(input int n, input string tag,
                        input logic [3:0] c3, input logic [3:0] c2,
                        input logic [3:0] c1, input logic [3:0] c0,
                        input logic u, input logic a);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 4'd0, tag, c3, c2, c1, c0, u, a);
        end
    endtask

    // Four digits. The last press moves the design into CHECK.
    task automatic enter_code(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        cyc(1'b1, 1'b0, a, "digit1", a, F, F, F, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, b, "digit2", a, b, F, F, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, c, "digit3", a, b, c, F, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, d, "check",  a, b, c, d, 1'b0, 1'b0);
    endtask

    task automatic wrong_entry(input logic [3:0] remaining);
        enter_code(4'd1, 4'd2, 4'd3, 4'd5);
        idle(4, "error_wait", F, F, F, remaining, 1'b0, 1'b0);
        idle(1, "error_exit", F, F, F, F, 1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        enter    = 1'b0;
        clear    = 1'b0;
        digit_in = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        push("reset_init", F, F, F, F, 1'b0, 1'b0);
        check_out();
        rst = 1'b0;

        // Correct code: OPEN lasts exactly 8 cycles, then ENTRY.
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        idle(8, "open", 4'd10, 4'd11, 4'd5, 4'd5, 1'b1, 1'b0);
        idle(1, "open_exit", F, F, F, F, 1'b0, 1'b0);

        // Wrong code twice: 2, then 1 attempts remaining.
        wrong_entry(4'd2);
        wrong_entry(4'd1);

        // Third wrong code: lockout for 16 cycles. Enter and clear are ignored.
        enter_code(4'd1, 4'd2, 4'd3, 4'd5);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, (i % 5) == 3, 4'(i % 10), "lockout", F, F, F, F, 1'b0, 1'b1);
        end
        cyc(1'b1, 1'b0, 4'd7, "lockout_exit", F, F, F, F, 1'b0, 1'b0);

        // Invalid digit ignored. Clear beats a simultaneous enter.
        cyc(1'b1, 1'b0, 4'd1,  "s5_d1",      4'd1, F, F, F, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'd12, "s5_invalid", 4'd1, F, F, F, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'd2,  "s5_d2",      4'd1, 4'd2, F, F, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4'd3,  "s5_clear",   F, F, F, F, 1'b0, 1'b0);
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        idle(2, "s5_open", 4'd10, 4'd11, 4'd5, 4'd5, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 4'd0, "s5_open_clear", F, F, F, F, 1'b0, 1'b0);

        // The failure count was reset by the lockout and by the unlock.
        // First failure: exit ERROR early with clear.
        enter_code(4'd1, 4'd2, 4'd3, 4'd5);
        idle(1, "s6_err1", F, F, F, 4'd2, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'd0, "s6_err_clear", F, F, F, F, 1'b0, 1'b0);
        wrong_entry(4'd1);
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        idle(2, "s6_open", 4'd10, 4'd11, 4'd5, 4'd5, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 4'd0, "s6_open_clear", F, F, F, F, 1'b0, 1'b0);
        wrong_entry(4'd2);
        wrong_entry(4'd1);
        enter_code(4'd1, 4'd2, 4'd3, 4'd5);
        idle(3, "s6_lockout", F, F, F, F, 1'b0, 1'b1);

        // Async reset in the middle of LOCKOUT takes effect with no clock edge.
        rst = 1'b1;
        #2;
        push("reset_async", F, F, F, F, 1'b0, 1'b0);
        check_out();
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 4'd9, "post_reset_d1", 4'd9, F, F, F, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so that the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
